imem_loader: RTL

- Boot-time program loader. It is the writer side of the CPU's instruction-memory fetch path.
- Accepts a byte stream over a valid/ready handshake, assembles 32-bit instruction words, and writes them sequentially into instruction memory from word address 0.
- Holds the CPU in reset until a complete image with a valid checksum has been written.
- Sits between the host/UART byte source and the imem write port, alongside the CPU top.

---
 rtl/imem_loader.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time program loader: the writer side of the CPU instruction-memory
// path. It accepts a byte stream over a valid/ready handshake, assembles
// little-endian 32-bit instruction words, and writes them sequentially into
// instruction memory from word address 0. The CPU is held in reset until a
// complete image with a good checksum has been written.
//
// Stream format: LEN_LO, LEN_HI (N = 16-bit word count, little-endian),
// N*4 payload bytes (each word little-endian), one checksum byte. The
// checksum is the XOR of the payload bytes only.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   start         one-cycle pulse; arms a load from IDLE, DONE or ERR
//   in_valid      byte source has data
//   in_data       stream byte
//   in_ready      loader accepts a byte this cycle (decoded from state)
//   imem_we       one-cycle imem write strobe
//   imem_addr     word address of the write
//   imem_wdata    instruction word
//   cpu_rst       CPU reset; low only in DONE
//   busy          load in progress (LEN_LO..CSUM)
//   done          image loaded with a good checksum
//   err           load aborted (bad checksum or oversize length)
//   words_loaded  words written in the current load
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  // Largest legal word count: exactly fills the memory.
  localparam int unsigned CAP = 32'd1 << ADDR_W;

  state_t      state;
  logic [7:0]  len_lo;      // low length byte, held until the high byte arrives
  logic [15:0] len_q;       // word count N for the current load
  logic [1:0]  byte_idx;    // position of the next payload byte within its word
  logic [23:0] word_lo;     // first three bytes of the word being assembled
  logic [7:0]  acc;         // running XOR of payload bytes
  logic        accept;
  logic [15:0] len_full;

  assign accept   = in_valid && in_ready;
  assign len_full = {in_data, len_lo};

  // NOTE: every signal written in always_comb gets a default first so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    unique case (state)
      S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_DONE:  done = 1'b1;
      S_ERR:   err  = 1'b1;
      default: ;
    endcase
    // The start term re-holds the CPU in the very cycle a reload is requested,
    // before the state register has left DONE.
    cpu_rst = (state != S_DONE) || start;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
      acc          <= '0;
      len_lo       <= '0;
      len_q        <= '0;
      byte_idx     <= '0;
      word_lo      <= '0;
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state        <= S_LEN_LO;
            words_loaded <= '0;
            acc          <= '0;
            byte_idx     <= '0;
          end
        end

        S_LEN_LO: begin
          if (accept) begin
            len_lo <= in_data;
            state  <= S_LEN_HI;
          end
        end

        S_LEN_HI: begin
          if (accept) begin
            len_q <= len_full;
            if (32'(len_full) > CAP)
              state <= S_ERR;
            else if (len_full == 16'd0)
              state <= S_CSUM;
            else
              state <= S_DATA;
          end
        end

        S_DATA: begin
          if (accept) begin
            acc      <= acc ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              // Fourth byte completes the word; the write issues next cycle
              // and the count advances with it.
              imem_we      <= 1'b1;
              imem_addr    <= words_loaded[ADDR_W-1:0];
              imem_wdata   <= {in_data, word_lo};
              words_loaded <= words_loaded + (ADDR_W+1)'(1);
              if (32'(words_loaded) + 32'd1 == 32'(len_q))
                state <= S_CSUM;
            end else begin
              // Shift right so the first byte lands in the lowest lane.
              word_lo <= {in_data, word_lo[23:8]};
            end
          end
        end

        S_CSUM: begin
          if (accept)
            state <= ((acc ^ in_data) == 8'd0) ? S_DONE : S_ERR;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
